// File: rtl/wr_acc.sv
// wr_acc: turns a level-handshaked register write request from the PCIe domain into a
// single-beat IP bus master write and returns {address, status code} as a response.
module wr_acc #(
  parameter logic [31:0] ACK_CODE  = 32'h1,
  parameter logic [31:0] NACK_CODE = 32'h2,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        reg_int_clk,
  input  logic        reg_int_reset_n,
  input  logic [31:0] acc_addr,
  input  logic [31:0] acc_data,
  input  logic        acc_en,
  output logic        acc_en_ack,
  output logic        IP2Bus_MstWr_Req,
  output logic [31:0] IP2Bus_Mst_Addr,
  output logic [31:0] IP2Bus_MstWr_d,
  output logic        IP2Bus_MstWr_src_rdy_n,
  input  logic        Bus2IP_MstWr_dst_rdy_n,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic        Bus2IP_Mst_Cmplt,
  input  logic        Bus2IP_Mst_Error,
  output logic        snd_resp,
  input  logic        snd_resp_ack,
  output logic [63:0] resp,
  input  logic        my_regif,
  output logic        drv_regif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT  = 3'd1,
    CMD  = 3'd2,
    DATA = 3'd3,
    CPL  = 3'd4,
    RESP = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        en_meta_q, en_sync_q;
  logic        rack_meta_q, rack_sync_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        req_q, req_d;
  logic [31:0] mst_addr_q, mst_addr_d;
  logic [31:0] mst_d_q, mst_d_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        snd_resp_q, snd_resp_d;
  logic [63:0] resp_q, resp_d;
  logic        drv_q, drv_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_s;
  logic        fin_s;
  logic [31:0] fin_code_s;

  // Two-flop synchronizers for the PCIe-domain handshake levels.
  always_ff @(posedge reg_int_clk or negedge reg_int_reset_n) begin
    if (!reg_int_reset_n) begin
      en_meta_q   <= 1'b0;
      en_sync_q   <= 1'b0;
      rack_meta_q <= 1'b0;
      rack_sync_q <= 1'b0;
    end else begin
      en_meta_q   <= acc_en;
      en_sync_q   <= en_meta_q;
      rack_meta_q <= snd_resp_ack;
      rack_sync_q <= rack_meta_q;
    end
  end

  // A transfer ends on a completion, or on timeout; a completion in the same cycle wins.
  always_comb begin
    busy_s = (state_q == CMD) || (state_q == DATA) || (state_q == CPL);
    fin_s  = busy_s && (Bus2IP_Mst_Cmplt || (cnt_q == TMO_LAST));
    if (Bus2IP_Mst_Cmplt && !Bus2IP_Mst_Error) begin
      fin_code_s = ACK_CODE;
    end else begin
      fin_code_s = NACK_CODE;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ack_d       = ack_q;
    req_d       = req_q;
    mst_addr_d  = mst_addr_q;
    mst_d_d     = mst_d_q;
    src_rdy_n_d = src_rdy_n_q;
    snd_resp_d  = snd_resp_q;
    resp_d      = resp_q;
    drv_d       = drv_q;
    cnt_d       = cnt_q;

    if (busy_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // The request acknowledge falls as soon as the requester has let go, whatever the state.
    if (ack_q && !en_sync_q) begin
      ack_d = 1'b0;
    end else begin
      ack_d = ack_q;
    end

    case (state_q)
      IDLE: begin
        if (en_sync_q) begin
          addr_d  = acc_addr;
          data_d  = acc_data;
          ack_d   = 1'b1;
          drv_d   = 1'b1;
          state_d = GNT;
        end else begin
          state_d = IDLE;
        end
      end
      GNT: begin
        if (my_regif) begin
          req_d      = 1'b1;
          mst_addr_d = addr_q;
          cnt_d      = 16'd0;
          state_d    = CMD;
        end else begin
          state_d = GNT;
        end
      end
      CMD, DATA, CPL: begin
        if (fin_s) begin
          req_d       = 1'b0;
          src_rdy_n_d = 1'b1;
          drv_d       = 1'b0;
          resp_d      = {addr_q, fin_code_s};
          state_d     = RESP;
        end else if ((state_q == CMD) && Bus2IP_Mst_CmdAck) begin
          req_d       = 1'b0;
          src_rdy_n_d = 1'b0;
          mst_d_d     = data_q;
          state_d     = DATA;
        end else if ((state_q == DATA) && !Bus2IP_MstWr_dst_rdy_n) begin
          src_rdy_n_d = 1'b1;
          state_d     = CPL;
        end else begin
          state_d = state_q;
        end
      end
      RESP: begin
        if (!snd_resp_q) begin
          if (!en_sync_q && !ack_q) begin
            snd_resp_d = 1'b1;
          end else begin
            snd_resp_d = 1'b0;
          end
        end else if (rack_sync_q) begin
          snd_resp_d = 1'b0;
          state_d    = DONE;
        end else begin
          snd_resp_d = 1'b1;
        end
      end
      DONE: begin
        if (!rack_sync_q) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge reg_int_clk or negedge reg_int_reset_n) begin
    if (!reg_int_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      ack_q       <= 1'b0;
      req_q       <= 1'b0;
      mst_addr_q  <= 32'h0;
      mst_d_q     <= 32'h0;
      src_rdy_n_q <= 1'b1;
      snd_resp_q  <= 1'b0;
      resp_q      <= 64'h0;
      drv_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      req_q       <= req_d;
      mst_addr_q  <= mst_addr_d;
      mst_d_q     <= mst_d_d;
      src_rdy_n_q <= src_rdy_n_d;
      snd_resp_q  <= snd_resp_d;
      resp_q      <= resp_d;
      drv_q       <= drv_d;
      cnt_q       <= cnt_d;
    end
  end

  assign acc_en_ack             = ack_q;
  assign IP2Bus_MstWr_Req       = req_q;
  assign IP2Bus_Mst_Addr        = mst_addr_q;
  assign IP2Bus_MstWr_d         = mst_d_q;
  assign IP2Bus_MstWr_src_rdy_n = src_rdy_n_q;
  assign snd_resp               = snd_resp_q;
  assign resp                   = resp_q;
  assign drv_regif              = drv_q;

endmodule

// File: tb/tb_wr_acc.sv
// Self-checking bench for wr_acc: directed vector table, hand-written corner sequences
// and randomized writes checked against a rule-level response model.
module tb_wr_acc;

  localparam logic [31:0] ACK  = 32'h1;
  localparam logic [31:0] NACK = 32'h2;
  localparam int TMO     = 16;
  localparam int M_NORM  = 0;  // CmdAck, data beat, completion in CPL
  localparam int M_TMO   = 1;  // CmdAck, data beat, completion never comes
  localparam int M_EARLY = 2;  // completion instead of CmdAck, while in CMD

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] acc_addr, acc_data;
  logic        acc_en, acc_en_ack;
  logic        req, src_rdy_n, dst_rdy_n, cmd_ack, cmplt, err_in;
  logic [31:0] mst_addr, mst_d;
  logic        snd_resp, snd_resp_ack, my_regif, drv_regif;
  logic [63:0] resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wr_acc #(.ACK_CODE(ACK), .NACK_CODE(NACK), .TIMEOUT(TMO)) dut (
    .reg_int_clk(clk), .reg_int_reset_n(rst_n),
    .acc_addr(acc_addr), .acc_data(acc_data), .acc_en(acc_en), .acc_en_ack(acc_en_ack),
    .IP2Bus_MstWr_Req(req), .IP2Bus_Mst_Addr(mst_addr), .IP2Bus_MstWr_d(mst_d),
    .IP2Bus_MstWr_src_rdy_n(src_rdy_n), .Bus2IP_MstWr_dst_rdy_n(dst_rdy_n),
    .Bus2IP_Mst_CmdAck(cmd_ack), .Bus2IP_Mst_Cmplt(cmplt), .Bus2IP_Mst_Error(err_in),
    .snd_resp(snd_resp), .snd_resp_ack(snd_resp_ack), .resp(resp),
    .my_regif(my_regif), .drv_regif(drv_regif)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          gnt_dly;
    int          ack_dly;
    int          dst_dly;
    int          mode;
    bit          err;
    logic [63:0] exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Response rule: a timeout or a bus error gives NACK, anything else ACK.
  function automatic logic [63:0] ref_resp(input logic [31:0] a, input int mode, input bit e);
    if (mode == M_TMO || e) return {a, NACK};
    return {a, ACK};
  endfunction

  task automatic wait_ack();
    int n = 0;
    while (!acc_en_ack && n < 100) begin @(negedge clk); n++; end
    check("acc_en_ack_rise", acc_en_ack, 1'b1);
  endtask

  task automatic pcie_req(input logic [31:0] a, input logic [31:0] d);
    acc_addr = a;
    acc_data = d;
    acc_en   = 1'b1;
    wait_ack();
    acc_en = 1'b0;
  endtask

  task automatic pcie_wait_resp(output logic [63:0] r);
    int n = 0;
    while (!snd_resp && n < 200) begin @(negedge clk); n++; end
    check("snd_resp_rise", snd_resp, 1'b1);
    check("ack_low_at_resp", acc_en_ack, 1'b0);
    r = resp;
  endtask

  task automatic pcie_finish(input logic [63:0] r);
    int n = 0;
    bit moved = 1'b0;
    snd_resp_ack = 1'b1;
    while (snd_resp && n < 30) begin
      if (resp !== r) moved = 1'b1;
      @(negedge clk);
      n++;
    end
    check("resp_stable", moved, 1'b0);
    check("snd_resp_fall", snd_resp, 1'b0);
    snd_resp_ack = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_side(input int gnt_dly, input int ack_dly, input int dst_dly,
                          input int mode, input bit e,
                          output logic [31:0] o_addr, output logic [31:0] o_data,
                          output int o_tmo);
    int n = 0;
    int t = 0;
    bit bad_req = 1'b0;
    bit bad_drv = 1'b0;
    o_addr = 32'h0;
    o_data = 32'h0;
    o_tmo  = -1;
    while (!drv_regif && n < 300) begin @(negedge clk); n++; end
    check("drv_regif_rise", drv_regif, 1'b1);
    repeat (gnt_dly) begin
      @(negedge clk);
      if (req) bad_req = 1'b1;
      if (!drv_regif) bad_drv = 1'b1;
    end
    if (gnt_dly > 0) begin
      check("gnt_wait_req_low", bad_req, 1'b0);
      check("gnt_wait_drv_high", bad_drv, 1'b0);
    end
    check("req_before_grant", req, 1'b0);
    my_regif = 1'b1;
    @(negedge clk);
    check("req_one_cycle_after_grant", req, 1'b1);
    o_addr = mst_addr;
    repeat (ack_dly) begin @(negedge clk); t++; end
    if (mode == M_EARLY) begin
      cmplt = 1'b1; err_in = e;
      @(negedge clk); t++;
      cmplt = 1'b0; err_in = 1'b0;
      check("early_cpl_req_low", req, 1'b0);
      check("early_cpl_src_high", src_rdy_n, 1'b1);
    end else begin
      cmd_ack = 1'b1;
      @(negedge clk); t++;
      cmd_ack = 1'b0;
      check("req_drop_after_cmdack", req, 1'b0);
      check("src_rdy_low", src_rdy_n, 1'b0);
      o_data = mst_d;
      repeat (dst_dly) begin @(negedge clk); t++; end
      dst_rdy_n = 1'b0;
      @(negedge clk); t++;
      dst_rdy_n = 1'b1;
      check("src_rdy_high_after_beat", src_rdy_n, 1'b1);
      if (mode == M_NORM) begin
        cmplt = 1'b1; err_in = e;
        @(negedge clk); t++;
        cmplt = 1'b0; err_in = 1'b0;
      end else begin
        while (drv_regif && t < 60) begin @(negedge clk); t++; end
        o_tmo = t;
        check("tmo_req_idle", req, 1'b0);
        check("tmo_src_idle", src_rdy_n, 1'b1);
      end
    end
    check("drv_regif_fall", drv_regif, 1'b0);
    my_regif = 1'b0;
  endtask

  task automatic run_write(input vec_t v, input string tag);
    logic [63:0] r;
    logic [31:0] oa, od;
    int ot;
    fork
      begin
        pcie_req(v.addr, v.data);
        pcie_wait_resp(r);
        pcie_finish(r);
      end
      bus_side(v.gnt_dly, v.ack_dly, v.dst_dly, v.mode, v.err, oa, od, ot);
    join
    check({tag, "_resp"}, r, v.exp_resp);
    check({tag, "_bus_addr"}, oa, v.addr);
    if (v.mode != M_EARLY) check({tag, "_bus_data"}, od, v.data);
    if (v.mode == M_TMO) check({tag, "_tmo_cycles"}, ot, TMO);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctrl"}, {acc_en_ack, req, snd_resp, drv_regif, src_rdy_n}, 5'b00001);
    check({tag, "_addr"}, mst_addr, 32'h0);
    check({tag, "_data"}, mst_d, 32'h0);
    check({tag, "_resp"}, resp, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] r1, r2;
    logic [31:0] oa1, od1, oa2, od2;
    int ot1, ot2, n;
    bit early, quiet;
    vec_t rv;

    rst_n = 1'b0; acc_en = 1'b0; acc_addr = 32'h0; acc_data = 32'h0;
    dst_rdy_n = 1'b1; cmd_ack = 1'b0; cmplt = 1'b0; err_in = 1'b0;
    snd_resp_ack = 1'b0; my_regif = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vecs[0] = '{32'h10, 32'hCAFEF00D, 0, 2, 1, M_NORM, 1'b0, 64'h00000010_00000001};
    vecs[1] = '{32'h10, 32'hCAFEF00D, 0, 2, 1, M_NORM, 1'b1, 64'h00000010_00000002};
    vecs[2] = '{32'h20, 32'h12345678, 0, 0, 0, M_TMO,  1'b0, 64'h00000020_00000002};
    vecs[3] = '{32'h30, 32'hA5A5A5A5, 10, 1, 0, M_NORM, 1'b0, 64'h00000030_00000001};
    vecs[4] = '{32'h44, 32'h0BADBEEF, 2, 1, 0, M_EARLY, 1'b1, 64'h00000044_00000002};
    vecs[5] = '{32'hFFFFFFFC, 32'h5A5A0F0F, 1, 0, 2, M_EARLY, 1'b0, 64'hFFFFFFFC_00000001};
    for (int i = 0; i < 6; i++) run_write(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second request raised while the first response is pending.
    fork
      begin
        pcie_req(32'h60, 32'h11110001);
        pcie_wait_resp(r1);
        acc_addr = 32'h64; acc_data = 32'h22220002; acc_en = 1'b1;
        early = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (acc_en_ack || drv_regif) early = 1'b1;
        end
        check("b2b_no_early_start", early, 1'b0);
        pcie_finish(r1);
        wait_ack();
        acc_en = 1'b0;
        pcie_wait_resp(r2);
        pcie_finish(r2);
      end
      begin
        bus_side(0, 1, 0, M_NORM, 1'b0, oa1, od1, ot1);
        bus_side(0, 1, 0, M_NORM, 1'b0, oa2, od2, ot2);
      end
    join
    check("b2b_resp1", r1, {32'h60, ACK});
    check("b2b_resp2", r2, {32'h64, ACK});
    check("b2b_data1", od1, 32'h11110001);
    check("b2b_data2", od2, 32'h22220002);
    check("b2b_addr2", oa2, 32'h64);

    // Reset while the data beat is pending.
    acc_addr = 32'h50; acc_data = 32'h55; acc_en = 1'b1; my_regif = 1'b1;
    n = 0;
    while (!req && n < 50) begin @(negedge clk); n++; end
    check("rstdata_req", req, 1'b1);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check("rstdata_in_data", src_rdy_n, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rstdata");
    acc_en = 1'b0; my_regif = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (snd_resp || acc_en_ack || drv_regif) quiet = 1'b0;
    end
    check("rstdata_no_resp", quiet, 1'b1);
    run_write(vecs[0], "post_rst");

    for (int i = 0; i < 10; i++) begin
      rv.addr     = $urandom;
      rv.data     = $urandom;
      rv.gnt_dly  = $urandom_range(0, 5);
      rv.ack_dly  = $urandom_range(0, 4);
      rv.dst_dly  = $urandom_range(0, 4);
      rv.mode     = $urandom_range(0, 2);
      rv.err      = 1'($urandom_range(0, 1));
      rv.exp_resp = ref_resp(rv.addr, rv.mode, rv.err);
      run_write(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
